tmds_decoder: RTL and testbench
===============================

TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter CTL_RUN, default 8, meaning consecutive control tokens required to declare alignment.
REQ-002 SHALL have parameter SEARCH_TIMEOUT, default 4096, meaning cycles without alignment (or, when locked, without any control token) before a slip or unlock.
REQ-003 SHALL have parameter SLIP_HOLDOFF, default 16, meaning wait cycles after each bitslip pulse.
REQ-004 SHALL have parameter DISP_LIMIT, default 16, meaning disparity magnitude that raises disp_err.
REQ-005 SHALL have port pixelclk, input, 1, pixel clock; the only clock.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port din, input, 10, deserialised TMDS word; din[0] is the first bit on the wire.
REQ-008 SHALL have port dout, output, 8, decoded pixel byte.
REQ-009 SHALL have port c0, output, 1, decoded control bit 0.
REQ-010 SHALL have port c1, output, 1, decoded control bit 1.
REQ-011 SHALL have port de, output, 1, data enable.
REQ-012 SHALL have port bitslip, output, 1, one-cycle request to the deserialiser to shift word boundary by one bit.
REQ-013 SHALL have port aligned, output, 1, high while in LOCKED.
REQ-014 SHALL have port disp_err, output, 1, disparity error pulse.

Function
REQ-015 SHALL register din (stage 1) and register all decoded outputs (stage 2), giving 2-cycle latency from din to dout/c0/c1/de.
REQ-016 SHALL recognise control tokens 10'b1101010100 -> {c1,c0}=00, 10'b0010101011 -> 01, 10'b0101010100 -> 10, and 10'b1010101011 -> 11.
REQ-017 SHALL decode a non-control word as follows: d = din[9] ? ~din[7:0] : din[7:0]; dout[0] = d[0]; for i = 1..7, dout[i] = din[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-018 SHALL, when aligned=1 and the word is a control token, output de=0, c1/c0 per REQ-016, and dout=0.
REQ-019 SHALL, when aligned=1 and the word is not a control token, output de=1, dout per REQ-017, and hold c1/c0 at their last values.
REQ-020 SHALL, while aligned=0, force de=0, dout=0, c0=0 and c1=0.
REQ-021 SHALL implement FSM states SEARCH, SLIP, HOLD and LOCKED.
REQ-022 SHALL, in SEARCH, count consecutive control tokens (any of the four; a non-control word zeroes the run) and go to LOCKED when the run reaches CTL_RUN.
REQ-023 SHALL, in SEARCH, go to SLIP when a cycle counter started on SEARCH entry reaches SEARCH_TIMEOUT.
REQ-024 SHALL, when the lock and timeout conditions occur in the same cycle, give LOCKED priority.
REQ-025 SHALL, in SLIP, assert bitslip for exactly one cycle and then go to HOLD.
REQ-026 SHALL, in HOLD, wait SLIP_HOLDOFF cycles and then go to SEARCH with all counters cleared.
REQ-027 SHALL make aligned=1 effective on the cycle after the CTL_RUN-th control token is registered.
REQ-028 SHALL, in LOCKED, count cycles since the last control token and go to SEARCH when the count reaches SEARCH_TIMEOUT.
REQ-029 SHALL saturate all counters and never let them wrap.
REQ-030 SHALL keep disp_err at 0 without the macro of REQ-034.

Reset
REQ-031 SHALL, on rst_n low, immediately clear dout, c0, c1, de, bitslip, aligned, disp_err, every counter and both pipeline stages, and set the FSM to SEARCH.
REQ-032 SHALL, on reset mid-operation (including during SLIP), drop bitslip within the same asynchronous assertion.
REQ-033 SHALL resume in SEARCH on the first pixelclk edge after rst_n deasserts.

Configuration
REQ-034 SHALL, with macro TMDS_DEC_DISPARITY_CHK_EN defined, keep a signed 7-bit accumulator that adds (ones - zeros) of each data word while LOCKED, clears on every control token, and clears on each error.
REQ-035 SHALL, with TMDS_DEC_DISPARITY_CHK_EN defined, pulse disp_err for one cycle, aligned with the stage-2 output of the offending word, when the accumulator magnitude exceeds DISP_LIMIT.
REQ-036 SHALL, without TMDS_DEC_DISPARITY_CHK_EN, omit the accumulator logic and tie disp_err to 0.

Verification
REQ-037 SHALL verify lock: 8 x 10'b1101010100 then 10'b0100000000 -> aligned=1 after the 8th token, then de=1 with dout=8'h00 two cycles after the data word.
REQ-038 SHALL verify decoding: while locked, drive each of the 256 bytes through a reference DVI encoder model -> dout equals the source byte at 2-cycle latency with no disp_err.
REQ-039 SHALL verify control mapping: while locked, drive 10'b1010101011 -> de=0 and {c1,c0}=11; drive 10'b0010101011 -> {c1,c0}=01.
REQ-040 SHALL verify slip: feed a stream rotated 3 bits with the model applying rotation on each bitslip -> exactly 3 bitslip pulses, each followed by 16 HOLD cycles, and aligned=1 after the 3rd slip.
REQ-041 SHALL verify unlock: when locked, drive 4096 consecutive data words -> aligned falls and the FSM returns to SEARCH.
REQ-042 SHALL verify disparity (macro defined): drive a run of 10'b1111111100 words (+6 each) -> disp_err pulses on the 3rd word; assert rst_n=0 mid-stream -> all outputs are 0 at once.

Source files
------------

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel decoder with word-alignment FSM; TMDS_DEC_DISPARITY_CHK_EN enables the disparity check
module tmds_decoder #(
    parameter int CTL_RUN        = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_HOLDOFF   = 16,
    parameter int DISP_LIMIT     = 16
) (
    input  logic       pixelclk,
    input  logic       rst_n,
    input  logic [9:0] din,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       bitslip,
    output logic       aligned,
    output logic       disp_err
);

    localparam int CNT_MAX = (SEARCH_TIMEOUT > SLIP_HOLDOFF) ? SEARCH_TIMEOUT : SLIP_HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RUN_W   = $clog2(CTL_RUN + 1);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] TMO_V   = CNT_W'(SEARCH_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(SLIP_HOLDOFF);
    localparam logic [RUN_W-1:0] RUN_V   = RUN_W'(CTL_RUN);

    typedef enum logic [1:0] {SEARCH, SLIP, HOLD, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [9:0]       din_q;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [RUN_W-1:0] run, run_nxt, run_inc;
    logic             is_ctl;
    logic [1:0]       ctl_val;
    logic [7:0]       d_word;
    logic [7:0]       data_dec;

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
    assign run_inc = (run == RUN_V) ? run : run + RUN_W'(1);
    assign aligned = (state == LOCKED);
    assign bitslip = (state == SLIP);

    always_comb begin
        is_ctl  = 1'b1;
        ctl_val = 2'b00;
        case (din_q)
            10'b1101010100: ctl_val = 2'b00;
            10'b0010101011: ctl_val = 2'b01;
            10'b0101010100: ctl_val = 2'b10;
            10'b1010101011: ctl_val = 2'b11;
            default:        is_ctl  = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain
    always_comb begin
        data_dec    = '0;
        d_word      = din_q[9] ? ~din_q[7:0] : din_q[7:0];
        data_dec[0] = d_word[0];
        for (int i = 1; i < 8; i++) begin
            data_dec[i] = din_q[8] ? (d_word[i] ^ d_word[i-1]) : ~(d_word[i] ^ d_word[i-1]);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        run_nxt   = run;
        case (state)
            SEARCH: begin
                run_nxt = is_ctl ? run_inc : '0;
                cnt_nxt = cnt_inc;
                if (is_ctl && run_inc >= RUN_V) begin
                    state_nxt = LOCKED;
                    cnt_nxt   = '0;
                    run_nxt   = '0;
                end else if (cnt_inc >= TMO_V) begin
                    state_nxt = SLIP;
                    cnt_nxt   = '0;
                    run_nxt   = '0;
                end
            end
            SLIP: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
                run_nxt   = '0;
            end
            HOLD: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc >= HOLD_V) begin
                    state_nxt = SEARCH;
                    cnt_nxt   = '0;
                end
            end
            LOCKED: begin
                cnt_nxt = is_ctl ? '0 : cnt_inc;
                if (!is_ctl && cnt_inc >= TMO_V) begin
                    state_nxt = SEARCH;
                    cnt_nxt   = '0;
                    run_nxt   = '0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                cnt_nxt   = '0;
                run_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
            cnt   <= '0;
            run   <= '0;
            din_q <= '0;
            dout  <= '0;
            c0    <= 1'b0;
            c1    <= 1'b0;
            de    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            run   <= run_nxt;
            din_q <= din;
            if (state != LOCKED) begin
                dout <= '0;
                de   <= 1'b0;
                c0   <= 1'b0;
                c1   <= 1'b0;
            end else if (is_ctl) begin
                dout <= '0;
                de   <= 1'b0;
                c0   <= ctl_val[0];
                c1   <= ctl_val[1];
            end else begin
                dout <= data_dec;
                de   <= 1'b1;
            end
        end
    end

`ifdef TMDS_DEC_DISPARITY_CHK_EN
    localparam logic signed [7:0] LIM_P = DISP_LIMIT[7:0];

    logic signed [6:0] disp_acc;
    logic [3:0]        ones;
    logic [7:0]        word_disp;
    logic [7:0]        disp_sum;
    logic              disp_over;

    always_comb begin
        ones = '0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + {3'b000, din_q[i]};
        end
        word_disp = {3'b000, ones, 1'b0} - 8'd10;
        disp_sum  = {disp_acc[6], disp_acc} + word_disp;
        disp_over = ($signed(disp_sum) > LIM_P) || ($signed(disp_sum) < -LIM_P);
    end

    // Accumulator restarts at every control token and after each reported error
    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            disp_acc <= '0;
            disp_err <= 1'b0;
        end else begin
            disp_err <= 1'b0;
            if (state != LOCKED || is_ctl) begin
                disp_acc <= '0;
            end else if (disp_over) begin
                disp_acc <= '0;
                disp_err <= 1'b1;
            end else begin
                disp_acc <= $signed(disp_sum[6:0]);
            end
        end
    end
`else
    assign disp_err = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - scoreboard bench for tmds_decoder with DVI encoder and deserialiser models
module tb_tmds_decoder;

    localparam int CTL_RUN = 8;
    localparam int TIMEOUT = 4096;
    localparam int HOLDOFF = 16;
    localparam int LIMIT   = 16;
    localparam int SLIP_GAP = 1 + HOLDOFF + TIMEOUT;

    localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    logic       pixelclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic [7:0] dout;
    logic       c0, c1, de, bitslip, aligned, disp_err;

    tmds_decoder #(
        .CTL_RUN(CTL_RUN), .SEARCH_TIMEOUT(TIMEOUT), .SLIP_HOLDOFF(HOLDOFF), .DISP_LIMIT(LIMIT)
    ) dut (
        .pixelclk(pixelclk), .rst_n(rst_n), .din(din), .dout(dout), .c0(c0), .c1(c1),
        .de(de), .bitslip(bitslip), .aligned(aligned), .disp_err(disp_err)
    );

    always #5 pixelclk = ~pixelclk;

    int cyc = 0;
    always @(posedge pixelclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected vector layout: {aligned, de, c1, c0, disp_err, dout}
    typedef struct {
        int          due;
        bit          care;
        logic [12:0] exp;
        string       name;
    } entry_t;

    entry_t sb[$];
    entry_t mon_e;

    always @(negedge pixelclk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: expectation due at cycle %0d never compared", mon_e.name, mon_e.due);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.care)
                check(mon_e.name, 32'({aligned, de, c1, c0, disp_err, dout}), 32'(mon_e.exp));
        end
    end

    // Word-level reference: lock after CTL_RUN tokens, unlock after TIMEOUT data words
    bit         m_locked;
    int         m_run, m_nctl, m_acc, enc_cnt;
    logic [1:0] m_c;

    function automatic void model_reset();
        m_locked = 0; m_run = 0; m_nctl = 0; m_acc = 0; m_c = 2'b00; enc_cnt = 0;
    endfunction

    function automatic logic [7:0] spec_decode(input logic [9:0] w);
        logic [7:0] d, r;
        d = w[9] ? ~w[7:0] : w[7:0];
        r[0] = d[0];
        for (int i = 1; i < 8; i++) r[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return r;
    endfunction

    function automatic logic [9:0] tmds_encode(input logic [7:0] dat);
        int n1, n1q, n0q, qm8;
        bit use_xnor;
        logic [8:0] qm;
        logic [9:0] q;
        n1 = $countones(dat);
        use_xnor = (n1 > 4) || (n1 == 4 && dat[0] == 1'b0);
        qm[0] = dat[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ dat[i]) : (qm[i-1] ^ dat[i]);
        qm[8] = !use_xnor;
        qm8 = use_xnor ? 0 : 1;
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_cnt += (qm8 == 1) ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += 2 * qm8 + (n0q - n1q);
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_cnt += -2 * (1 - qm8) + (n1q - n0q);
        end
        return q;
    endfunction

    function automatic logic [12:0] model_step(input logic [9:0] w, input logic [7:0] src, input bit src_known);
        int idx;
        logic [7:0] o_d;
        logic [1:0] o_c;
        logic o_de, o_err;
        idx = -1;
        for (int k = 0; k < 4; k++) if (w == TOK[k]) idx = k;
        o_d = 8'h00; o_c = 2'b00; o_de = 1'b0; o_err = 1'b0;
        if (m_locked) begin
            if (idx >= 0) begin
                o_c = 2'(idx);
                m_c = o_c;
                m_acc = 0;
            end else begin
                o_de = 1'b1;
                o_d  = src_known ? src : spec_decode(w);
                o_c  = m_c;
`ifdef TMDS_DEC_DISPARITY_CHK_EN
                m_acc += 2 * $countones(w) - 10;
                if (m_acc > LIMIT || m_acc < -LIMIT) begin
                    o_err = 1'b1;
                    m_acc = 0;
                end
`endif
            end
        end else begin
            m_c = 2'b00;
            m_acc = 0;
        end
        if (!m_locked) begin
            m_run = (idx >= 0) ? m_run + 1 : 0;
            if (m_run >= CTL_RUN) begin
                m_locked = 1;
                m_nctl = 0;
            end
        end else begin
            m_nctl = (idx >= 0) ? 0 : m_nctl + 1;
            if (m_nctl >= TIMEOUT) begin
                m_locked = 0;
                m_run = 0;
            end
        end
        return {m_locked, o_de, o_c, o_err, o_d};
    endfunction

    task automatic send(input logic [9:0] w, input logic [7:0] src, input bit src_known, input string name);
        entry_t e;
        e.exp  = model_step(w, src, src_known);
        e.due  = cyc + 2;
        e.care = 1'b1;
        e.name = name;
        sb.push_back(e);
        din = w;
        @(posedge pixelclk);
        #1;
    endtask

    task automatic send_tok(input int k);
        enc_cnt = 0;
        send(TOK[k], 8'h00, 1'b0, "ctl");
    endtask

    task automatic send_byte(input logic [7:0] b, input string name);
        send(tmds_encode(b), b, 1'b1, name);
    endtask

    // Serial line model: 3 stray bits ahead of the stream, each bitslip drops one bit
    bit bq[$];
    int pidx;

    task automatic init_rot();
        bq.delete();
        repeat (3) bq.push_back(1'b0);
        pidx = 0;
    endtask

    task automatic drive_rot();
        logic [9:0] tx, w;
        if (bitslip) void'(bq.pop_front());
        while (bq.size() < 21) begin
            if (pidx % 12 < 10) begin
                tx = TOK[0];
                enc_cnt = 0;
            end else begin
                tx = tmds_encode(8'($urandom_range(0, 255)));
            end
            pidx++;
            for (int i = 0; i < 10; i++) bq.push_back(tx[i]);
        end
        for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
        din = w;
        @(posedge pixelclk);
        #1;
    endtask

    task automatic pulse_reset(input string name);
        #2;
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check(name, 32'({dout, c0, c1, de, bitslip, aligned, disp_err}), 32'd0);
        @(posedge pixelclk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] w;
        int slip_cyc[$];
        int hi_cycles, lock_cyc, extra_hi, extra_lo;
        bit prev_bs;

        model_reset();
        repeat (3) @(posedge pixelclk);
        #1;
        check("reset_state", 32'({dout, c0, c1, de, bitslip, aligned, disp_err}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) send_tok(0);
        send(10'b0100000000, 8'h00, 1'b1, "lock_data");

        for (int b = 0; b < 256; b++) begin
            if ($urandom_range(0, 7) == 0) send_tok(int'($urandom_range(0, 3)));
            send_byte(8'(b), "byte_sweep");
        end

        send_tok(3);
        send_byte(8'($urandom_range(0, 255)), "hold_c11");
        send_tok(1);
        send_byte(8'($urandom_range(0, 255)), "hold_c01");
        send_tok(2);

        for (int i = 0; i < 64; i++) begin
            w = 10'($urandom_range(0, 1023));
            if (w == TOK[0] || w == TOK[1] || w == TOK[2] || w == TOK[3]) w = 10'b0100000000;
            send(w, 8'h00, 1'b0, "raw_word");
        end

        send_tok(0);
        for (int i = 0; i < 5; i++) send(10'b1111111100, 8'h00, 1'b0, "disparity_run");
        send_byte(8'hA5, "pre_reset");
        send_byte(8'h3C, "pre_reset");
        pulse_reset("midstream_reset");

        for (int i = 0; i < 8; i++) send_tok(1);
        for (int i = 0; i < TIMEOUT + 4; i++) send_byte(8'($urandom_range(0, 255)), "unlock_run");
        for (int i = 0; i < 8; i++) send_tok(2);
        send_byte(8'h5A, "relock_data");
        repeat (3) begin
            @(posedge pixelclk);
            #1;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        rst_n = 1'b0;
        #1;
        @(posedge pixelclk);
        #1;
        rst_n = 1'b1;
        init_rot();
        for (int n = 0; n < SLIP_GAP + 100 && !bitslip; n++) drive_rot();
        check("first_slip_seen", 32'(bitslip), 32'd1);
        pulse_reset("reset_during_slip");

        init_rot();
        hi_cycles = 0;
        lock_cyc = -1;
        prev_bs = 1'b0;
        for (int n = 0; n < 3 * SLIP_GAP + 400 && lock_cyc < 0; n++) begin
            if (bitslip) begin
                hi_cycles++;
                if (!prev_bs) slip_cyc.push_back(cyc);
            end
            if (aligned) lock_cyc = cyc;
            prev_bs = bitslip;
            drive_rot();
        end
        check("slip_pulses", 32'(slip_cyc.size()), 32'd3);
        check("slip_high_cycles", 32'(hi_cycles), 32'd3);
        check("locked_after_slips", 32'(lock_cyc >= 0), 32'd1);
        if (slip_cyc.size() >= 3) begin
            check("slip_gap_1", 32'(slip_cyc[1] - slip_cyc[0]), 32'(SLIP_GAP));
            check("slip_gap_2", 32'(slip_cyc[2] - slip_cyc[1]), 32'(SLIP_GAP));
            check("lock_after_hold",
                  32'((lock_cyc - slip_cyc[2] > HOLDOFF) && (lock_cyc - slip_cyc[2] < HOLDOFF + 60)), 32'd1);
        end
        extra_hi = 0;
        extra_lo = 0;
        for (int n = 0; n < 300; n++) begin
            if (bitslip) extra_hi++;
            if (!aligned) extra_lo++;
            drive_rot();
        end
        check("no_extra_slip", 32'(extra_hi), 32'd0);
        check("stays_aligned", 32'(extra_lo), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
